// File: rtl/link_health_monitor_pkg.sv
// Link health monitor package: state type, event-byte layout and event builder.
package link_health_monitor_pkg;

`include "link_mon_defs.vh"

    typedef enum logic [1:0] {
        ST_HUNT   = `LM_ST_HUNT,
        ST_SYNC   = `LM_ST_SYNC,
        ST_LOCKED = `LM_ST_LOCKED,
        ST_LOST   = `LM_ST_LOST
    } lm_state_t;

    localparam int unsigned EVT_OVR_BIT = `LM_EVT_OVR_BIT;

    function automatic logic [7:0] make_evt(input lm_state_t st, input logic [2:0] flags);
        logic [7:0] b;
        b = '0;
        b[`LM_EVT_STATE_HI:`LM_EVT_STATE_LO] = st;
        b[`LM_EVT_FLAGS_HI:`LM_EVT_FLAGS_LO] = flags;
        return b;
    endfunction

endpackage

// File: rtl/link_health_monitor_if.sv
// Symbol input, status and debug-event stream signals of the link health monitor.
interface link_health_monitor_if;
    logic        i_sym_valid;
    logic [2:0]  i_sym_error;
    logic        i_clear;
    logic [1:0]  o_state;
    logic        o_link_up;
    logic [15:0] o_err_count;
    logic        o_evt_valid;
    logic [7:0]  o_evt_data;
    logic        i_evt_ready;

    modport master (
        output i_sym_valid, i_sym_error, i_clear, i_evt_ready,
        input  o_state, o_link_up, o_err_count, o_evt_valid, o_evt_data
    );

    modport slave (
        input  i_sym_valid, i_sym_error, i_clear, i_evt_ready,
        output o_state, o_link_up, o_err_count, o_evt_valid, o_evt_data
    );
endinterface

// File: rtl/link_mon_defs.vh
// Shared link-monitor definitions: state encodings and event-byte field positions.
`ifndef LINK_MON_DEFS_VH
`define LINK_MON_DEFS_VH

`define LM_ST_HUNT      2'b00
`define LM_ST_SYNC      2'b01
`define LM_ST_LOCKED    2'b10
`define LM_ST_LOST      2'b11

`define LM_EVT_STATE_HI 7
`define LM_EVT_STATE_LO 6
`define LM_EVT_OVR_BIT  5
`define LM_EVT_FLAGS_HI 2
`define LM_EVT_FLAGS_LO 0

`endif

// File: rtl/link_mon_evt_reg.sv
// Single-entry status event holding register with valid/ready handshake and overrun flag.
module link_mon_evt_reg
    import link_health_monitor_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_post,
    input  logic [7:0] i_post_data,
    input  logic       i_evt_ready,
    output logic       o_evt_valid,
    output logic [7:0] o_evt_data
);

    logic [7:0] load_data;

    // Overrun only when the pending event is replaced without having been taken.
    always_comb begin
        load_data = i_post_data;
        load_data[EVT_OVR_BIT] = o_evt_valid && !i_evt_ready;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_evt_valid <= 1'b0;
            o_evt_data  <= '0;
        end else if (i_post) begin
            o_evt_valid <= 1'b1;
            o_evt_data  <= load_data;
        end else if (o_evt_valid && i_evt_ready) begin
            o_evt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/link_health_monitor.sv
// 8b10b link health monitor: HUNT/SYNC/LOCKED/LOST tracking, error total, status events.
// Optional inactivity timeout enabled by defining LINK_MON_TIMEOUT_EN.
module link_health_monitor
    import link_health_monitor_pkg::*;
#(
    parameter int unsigned CLK_RATE_HZ = 60_000_000,
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned WINDOW_SYMS = 256,
    parameter int unsigned LOSS_ERR    = 4,
    parameter int unsigned TIMEOUT_US  = 100
) (
    input  logic i_clk,
    input  logic i_reset,
    link_health_monitor_if.slave lm
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = (WINDOW_SYMS > 1) ? $clog2(WINDOW_SYMS) : 1;
    localparam int unsigned EW = $clog2(LOSS_ERR + 1);

    lm_state_t   state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [EW-1:0] win_err, werr_n;
    logic [15:0] err_count;
    logic [2:0]  last_flags, evt_flags;
    logic        sym_ok, sym_bad;
    logic        timeout;

    assign sym_ok  = lm.i_sym_valid && (lm.i_sym_error == '0);
    assign sym_bad = lm.i_sym_valid && (lm.i_sym_error != '0);

`ifdef LINK_MON_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = CLK_RATE_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (lm.i_sym_valid || state == ST_HUNT || state == ST_LOST) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle, so the state moves on that edge.
    assign timeout = !lm.i_sym_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1)) &&
                     (state == ST_SYNC || state == ST_LOCKED);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{CLK_RATE_HZ, TIMEOUT_US};
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        win_n   = win_cnt;
        werr_n  = win_err;
        unique case (state)
            ST_HUNT: begin
                if (sym_ok) begin
                    state_n = ST_SYNC;
                    good_n  = GW'(1);
                end
            end
            ST_SYNC: begin
                if (sym_bad) begin
                    state_n = ST_HUNT;
                end else if (sym_ok) begin
                    good_n = good_cnt + GW'(1);
                    if (good_n == GW'(LOCK_CNT)) begin
                        state_n = ST_LOCKED;
                        win_n   = '0;
                        werr_n  = '0;
                    end
                end else if (timeout) begin
                    state_n = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (lm.i_sym_valid) begin
                    // The wrapping symbol is the first one counted in the new window.
                    if (win_cnt == WW'(WINDOW_SYMS - 1)) begin
                        win_n  = '0;
                        werr_n = EW'(sym_bad);
                    end else begin
                        win_n  = win_cnt + WW'(1);
                        werr_n = win_err + EW'(sym_bad);
                    end
                    if (werr_n >= EW'(LOSS_ERR)) begin
                        state_n = ST_LOST;
                    end
                end else if (timeout) begin
                    state_n = ST_LOST;
                end
            end
            ST_LOST: begin
                state_n = ST_HUNT;
            end
            default: state_n = ST_HUNT;
        endcase
        if (state_n == ST_HUNT) begin
            good_n = '0;
            win_n  = '0;
            werr_n = '0;
        end
    end

    // Event flags are those of the symbol that caused the entry; input is ignored in LOST.
    always_comb begin
        evt_flags = last_flags;
        if (lm.i_sym_valid && state != ST_LOST) begin
            evt_flags = lm.i_sym_error;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_HUNT;
            good_cnt   <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            last_flags <= '0;
        end else begin
            state      <= state_n;
            good_cnt   <= good_n;
            win_cnt    <= win_n;
            win_err    <= werr_n;
            last_flags <= evt_flags;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_count <= '0;
        end else if (lm.i_clear) begin
            err_count <= sym_bad ? 16'd1 : 16'd0;
        end else if (sym_bad && err_count != '1) begin
            err_count <= err_count + 16'd1;
        end
    end

    link_mon_evt_reg u_evt_reg (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_post      (state_n != state),
        .i_post_data (make_evt(state_n, evt_flags)),
        .i_evt_ready (lm.i_evt_ready),
        .o_evt_valid (lm.o_evt_valid),
        .o_evt_data  (lm.o_evt_data)
    );

    assign lm.o_state     = state;
    assign lm.o_link_up   = (state == ST_LOCKED);
    assign lm.o_err_count = err_count;

endmodule

// File: doc/link_health_monitor.md
LINK_HEALTH_MONITOR -- requirements
Module: link_health_monitor

Interface
REQ-001 Parameter CLK_RATE_HZ, default 60_000_000, SHALL give the system clock rate used to derive the timeout.
REQ-002 Parameter LOCK_CNT, default 64, SHALL give the consecutive error-free symbols needed to declare lock.
REQ-003 Parameter WINDOW_SYMS, default 256, SHALL give the error-rate window length in valid symbols.
REQ-004 Parameter LOSS_ERR, default 4, SHALL give the errors within one window that declare loss.
REQ-005 Parameter TIMEOUT_US, default 100, SHALL give the inactivity time (no valid symbol) that declares loss.
REQ-006 Ports SHALL be: i_clk in 1 system clock; i_reset in 1 reset, asynchronous, active-high.
REQ-007 i_sym_valid in 1, decoded 8b10b symbol strobe; i_sym_error in 3, per-symbol error flags (nonzero = bad symbol).
REQ-008 i_clear in 1, synchronous clear of the error total.
REQ-009 o_state out 2, link state; o_link_up out 1, high only in LOCKED; o_err_count out 16, saturating error total.
REQ-010 o_evt_valid out 1, o_evt_data out 8, i_evt_ready in 1: status event stream for the debug UART.

Function
REQ-011 States SHALL be HUNT=00, SYNC=01, LOCKED=10, LOST=11; state and all outputs SHALL update on the i_clk edge after the sampled symbol (latency 1).
REQ-012 HUNT: valid error-free symbol -> SYNC with good count 1; errored symbol -> stay in HUNT.
REQ-013 SYNC: each valid error-free symbol increments good count; reaching LOCK_CNT -> LOCKED; any errored symbol -> HUNT, good count 0.
REQ-014 LOCKED: window counter counts valid symbols 0..WINDOW_SYMS-1 and wraps; error counter counts errored symbols; error count reaching LOSS_ERR -> LOST.
REQ-015 At window wrap the window error count SHALL restart at 0, or at 1 if the wrapping symbol is errored.
REQ-016 LOST SHALL last exactly one cycle and then go to HUNT, ignoring input during that cycle; counters SHALL clear on entry to HUNT.
REQ-017 o_err_count SHALL increment on every valid errored symbol in any state and saturate at 0xFFFF.
REQ-018 i_clear SHALL zero the count; if i_clear coincides with an errored symbol, the result SHALL be 1.
REQ-019 Every state entry SHALL post an event: o_evt_data = {state[1:0], overrun, 2'b00, last error flags[2:0]}.
REQ-020 An event SHALL be held stable with o_evt_valid high until i_evt_ready is sampled high; a transfer occurs on valid&&ready.
REQ-021 A new event arriving while one is pending SHALL replace it and set overrun=1 in the replacement.
REQ-022 Overrun SHALL clear after a successful transfer.
REQ-023 A new event coinciding with a transfer SHALL load with overrun=0.

Reset
REQ-024 On i_reset: state=HUNT, o_link_up=0, o_err_count=0, o_evt_valid=0, o_evt_data=0, all internal counters 0; reset mid-operation SHALL abandon any pending event.

Configuration
REQ-025 With LINK_MON_TIMEOUT_EN defined, a cycle counter SHALL clear on each valid symbol.
REQ-026 When that counter reaches CLK_RATE_HZ/1_000_000*TIMEOUT_US cycles: LOCKED -> LOST; SYNC -> HUNT.
REQ-027 Without LINK_MON_TIMEOUT_EN, no timeout logic SHALL exist, and loss SHALL occur only via REQ-014.

Structure
REQ-028 A shared include, link_mon_defs.vh, SHALL hold the state encodings and the event-byte field positions.
REQ-029 The event holding register and handshake (REQ-020 to REQ-023) SHALL be a sub-module named link_mon_evt_reg.

Verification
REQ-030 64 clean symbols after reset -> SYNC after symbol 1, LOCKED and o_link_up=1 one clock after symbol 64; events 0x40 then 0x80.
REQ-031 In SYNC at good count 30, one symbol with flags 3'b010 -> HUNT, event 0x02, o_err_count=1.
REQ-032 LOCKED, 4 errored symbols at positions 10/50/100/200 of one window -> LOST for 1 cycle then HUNT.
REQ-033 LOCKED, 3 errors in the window tail and 1 error on the wrap symbol -> stays LOCKED.
REQ-034 i_evt_ready held low across the HUNT->SYNC->LOCKED entries -> o_evt_data=0xA0 (overrun set); after ready, the next event has bit5=0.
REQ-035 With LINK_MON_TIMEOUT_EN, LOCKED with no valid symbols for 6000 clocks -> LOST at clock 6000.
REQ-036 Without LINK_MON_TIMEOUT_EN, the REQ-035 stimulus -> remains LOCKED.
REQ-037 0xFFFF errors followed by 1 more -> o_err_count stays at 0xFFFF.
